// File: rtl/z80_io_mailbox.sv
// Z80 I/O-mapped 8-port mailbox shared with a synchronous host.
// Z80 bus inputs are synchronized, then arbitrated against host requests by a small FSM.
module z80_io_mailbox #(
  parameter logic [15:0] BASE_ADDR = 16'h3038
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] z80_a,
  input  logic [7:0]  z80_d_in,
  input  logic        z80_rd,
  input  logic        z80_wr,
  input  logic        z80_m1,
  input  logic        z80_iorq,
  input  logic        z80_mreq,
  output logic [7:0]  z80_d_out,
  output logic        z80_d_oe,
  output logic        z80_wait_n,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [2:0]  host_addr,
  input  logic [7:0]  host_wdata,
  output logic [7:0]  host_rdata,
  output logic        host_ack,
  output logic [7:0]  z80_dirty
);

  typedef enum logic [2:0] {IDLE, Z80_RD, Z80_WR, Z80_END, HOST} state_t;

  state_t      state, next_state;
  logic [15:0] a_q1, a_s;
  logic [7:0]  d_q1, d_s;
  logic [4:0]  ctl_q1, ctl_s;
  logic        rd_s, wr_s, m1_s, iorq_s, mreq_s;
  logic        hit;
  logic [2:0]  z_idx;
  logic [7:0]  bank [8];

  // Reset parks the synchronizers at an idle bus, so a strobe still held
  // across reset is seen as a fresh falling edge afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q1   <= '0;
      a_s    <= '0;
      d_q1   <= '0;
      d_s    <= '0;
      ctl_q1 <= '1;
      ctl_s  <= '1;
    end else begin
      a_q1   <= z80_a;
      a_s    <= a_q1;
      d_q1   <= z80_d_in;
      d_s    <= d_q1;
      ctl_q1 <= {z80_rd, z80_wr, z80_m1, z80_iorq, z80_mreq};
      ctl_s  <= ctl_q1;
    end
  end

  assign {rd_s, wr_s, m1_s, iorq_s, mreq_s} = ctl_s;
  assign z_idx = a_s[2:0];
  assign hit   = !iorq_s && mreq_s && m1_s && (a_s[15:3] == BASE_ADDR[15:3]) && (!rd_s || !wr_s);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (hit)           next_state = !rd_s ? Z80_RD : Z80_WR;
        else if (host_req) next_state = HOST;
      end
      Z80_RD:  next_state = Z80_END;
      Z80_WR:  next_state = Z80_END;
      Z80_END: if (rd_s && wr_s) next_state = IDLE;
      HOST:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // wait_n and host_ack are registered from next_state so each is valid
  // exactly for the duration of the state it flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 8; i++) bank[i] <= '0;
      z80_dirty  <= '0;
      z80_d_out  <= '0;
      z80_d_oe   <= 1'b0;
      z80_wait_n <= 1'b1;
      host_rdata <= '0;
      host_ack   <= 1'b0;
    end else begin
      z80_wait_n <= !(next_state == Z80_RD || next_state == Z80_WR);
      host_ack   <= (next_state == HOST);
      case (state)
        Z80_RD: begin
          z80_d_out <= bank[z_idx];
          z80_d_oe  <= 1'b1;
        end
        Z80_WR: begin
          bank[z_idx]      <= d_s;
          z80_dirty[z_idx] <= 1'b1;
        end
        Z80_END: if (rd_s && wr_s) z80_d_oe <= 1'b0;
        HOST: begin
          if (host_we) begin
            bank[host_addr] <= host_wdata;
          end else begin
            host_rdata           <= bank[host_addr];
            z80_dirty[host_addr] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_io_mailbox.sv
// Directed self-checking bench for z80_io_mailbox.
module tb_z80_io_mailbox;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] z80_a;
  logic [7:0]  z80_d_in;
  logic        z80_rd, z80_wr, z80_m1, z80_iorq, z80_mreq;
  logic [7:0]  z80_d_out;
  logic        z80_d_oe, z80_wait_n;
  logic        host_req, host_we;
  logic [2:0]  host_addr;
  logic [7:0]  host_wdata, host_rdata;
  logic        host_ack;
  logic [7:0]  z80_dirty;

  int n_assert = 0;
  int n_fail   = 0;

  z80_io_mailbox #(.BASE_ADDR(16'h3038)) dut (
    .clk(clk), .rst(rst),
    .z80_a(z80_a), .z80_d_in(z80_d_in), .z80_rd(z80_rd), .z80_wr(z80_wr),
    .z80_m1(z80_m1), .z80_iorq(z80_iorq), .z80_mreq(z80_mreq),
    .z80_d_out(z80_d_out), .z80_d_oe(z80_d_oe), .z80_wait_n(z80_wait_n),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
    .z80_dirty(z80_dirty)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    z80_rd = 1'b1; z80_wr = 1'b1; z80_m1 = 1'b1; z80_iorq = 1'b1; z80_mreq = 1'b1;
  endtask

  // One in-window Z80 I/O cycle; strobes held until the block has finished.
  task automatic z80_cycle(input bit is_rd, input logic [15:0] addr,
                           input logic [7:0] data, input logic [7:0] exp_rd, input string tag);
    int lows = 0;
    bit seen = 1'b0;
    z80_a = addr; z80_d_in = data; z80_iorq = 1'b0;
    if (is_rd) z80_rd = 1'b0; else z80_wr = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (!z80_wait_n) seen = 1'b1;
    end
    check({tag, "_wait_seen"}, 16'(seen), 16'd1);
    while (!z80_wait_n && lows < 5) begin
      lows++;
      tick();
    end
    check({tag, "_wait_cycles"}, 16'(lows), 16'd1);
    tick();
    tick();
    if (is_rd) begin
      check({tag, "_doe_held"}, 16'(z80_d_oe), 16'd1);
      check({tag, "_dout"}, 16'(z80_d_out), 16'(exp_rd));
    end
    bus_idle();
    repeat (4) tick();
    check({tag, "_doe_released"}, 16'(z80_d_oe), 16'd0);
  endtask

  // Single host transaction; request dropped as soon as the ack is seen.
  task automatic host_op(input bit we, input logic [2:0] addr,
                         input logic [7:0] wdata, input string tag);
    bit seen = 1'b0;
    host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (host_ack) seen = 1'b1;
    end
    check({tag, "_ack_seen"}, 16'(seen), 16'd1);
    host_req = 1'b0;
    tick();
    check({tag, "_ack_single"}, 16'(host_ack), 16'd0);
  endtask

  // Bus activity that must not touch the mailbox.
  task automatic z80_ignored(input logic [15:0] addr, input logic rd, input logic wr,
                             input logic m1, input logic iorq, input logic mreq, input string tag);
    int lows = 0;
    int oes  = 0;
    z80_a = addr; z80_d_in = 8'hFF;
    z80_rd = rd; z80_wr = wr; z80_m1 = m1; z80_iorq = iorq; z80_mreq = mreq;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (!z80_wait_n) lows++;
      if (z80_d_oe) oes++;
    end
    check({tag, "_no_wait"}, 16'(lows), 16'd0);
    check({tag, "_no_doe"}, 16'(oes), 16'd0);
    bus_idle();
    repeat (3) tick();
  endtask

  initial begin
    int acks;
    int lows;
    bit seen;
    rst = 1'b1;
    bus_idle();
    z80_a = '0; z80_d_in = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (3) tick();
    check("rst_dout", 16'(z80_d_out), 16'h00);
    check("rst_doe", 16'(z80_d_oe), 16'd0);
    check("rst_wait_n", 16'(z80_wait_n), 16'd1);
    check("rst_rdata", 16'(host_rdata), 16'h00);
    check("rst_ack", 16'(host_ack), 16'd0);
    check("rst_dirty", 16'(z80_dirty), 16'h00);
    rst = 1'b0;
    tick();

    // Z80 OUT (0x303A),0x5A then host reads it back
    z80_cycle(1'b0, 16'h303A, 8'h5A, 8'h00, "out_303a");
    check("out_303a_dirty", 16'(z80_dirty), 16'h04);
    host_op(1'b0, 3'd2, 8'h00, "hrd2");
    check("hrd2_rdata", 16'(host_rdata), 16'h5A);
    check("hrd2_dirty", 16'(z80_dirty), 16'h00);

    // Host write, Z80 IN reads it; rdata holds across the host write
    host_op(1'b1, 3'd5, 8'hC3, "hwr5");
    check("hwr5_dirty", 16'(z80_dirty), 16'h00);
    check("hwr5_rdata_hold", 16'(host_rdata), 16'h5A);
    z80_cycle(1'b1, 16'h303D, 8'h00, 8'hC3, "in_303d");

    // Host request arrives on the same cycle the Z80 write decodes
    z80_a = 16'h3038; z80_d_in = 8'h77; z80_iorq = 1'b0; z80_wr = 1'b0;
    tick();
    tick();
    host_req = 1'b1; host_we = 1'b0; host_addr = 3'd0;
    tick();
    check("race_wait_low", 16'(z80_wait_n), 16'd0);
    check("race_no_ack", 16'(host_ack), 16'd0);
    repeat (3) tick();
    check("race_ack_blocked", 16'(host_ack), 16'd0);
    bus_idle();
    repeat (3) tick();
    check("race_ack_not_yet", 16'(host_ack), 16'd0);
    tick();
    check("race_ack", 16'(host_ack), 16'd1);
    host_req = 1'b0;
    tick();
    check("race_ack_single", 16'(host_ack), 16'd0);
    check("race_rdata", 16'(host_rdata), 16'h77);
    check("race_dirty", 16'(z80_dirty), 16'h00);

    // Held host request is served repeatedly
    acks = 0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 3'd7; host_wdata = 8'h11;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (host_ack) acks++;
    end
    host_req = 1'b0;
    tick();
    check("held_req_acks", 16'(acks), 16'd2);

    // Out-of-window, memory and interrupt-acknowledge cycles
    z80_ignored(16'h3040, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "in_3040");
    z80_ignored(16'h3040, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "out_3040");
    z80_ignored(16'h303D, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "memwr_303d");
    z80_ignored(16'h3038, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "memrd_3038");
    z80_ignored(16'h3038, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "m1_iorq");
    check("ignored_dirty", 16'(z80_dirty), 16'h00);
    host_op(1'b0, 3'd5, 8'h00, "hrd5");
    check("hrd5_rdata", 16'(host_rdata), 16'hC3);
    host_op(1'b0, 3'd0, 8'h00, "hrd0");
    check("hrd0_rdata", 16'(host_rdata), 16'h77);
    host_op(1'b0, 3'd7, 8'h00, "hrd7");
    check("hrd7_rdata", 16'(host_rdata), 16'h11);

    // Reset while a Z80 read is driving the bus; held rd re-triggers once
    z80_a = 16'h303D; z80_iorq = 1'b0; z80_rd = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (!z80_wait_n) seen = 1'b1;
    end
    check("rstmid_wait_seen", 16'(seen), 16'd1);
    tick();
    check("rstmid_doe_before", 16'(z80_d_oe), 16'd1);
    rst = 1'b1;
    tick();
    check("rstmid_doe", 16'(z80_d_oe), 16'd0);
    check("rstmid_wait_n", 16'(z80_wait_n), 16'd1);
    check("rstmid_dout", 16'(z80_d_out), 16'h00);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (!z80_wait_n) lows++;
    end
    check("rstmid_retrigger", 16'(lows), 16'd1);
    check("rstmid_doe_again", 16'(z80_d_oe), 16'd1);
    check("rstmid_dout_cleared", 16'(z80_d_out), 16'h00);
    bus_idle();
    repeat (4) tick();
    check("rstmid_doe_released", 16'(z80_d_oe), 16'd0);
    host_op(1'b0, 3'd0, 8'h00, "post_rst0");
    check("post_rst0_rdata", 16'(host_rdata), 16'h00);
    host_op(1'b0, 3'd5, 8'h00, "post_rst5");
    check("post_rst5_rdata", 16'(host_rdata), 16'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
